// File: rtl/ysyx_25060173_decode_pkg.sv
// Shared types for the NPC decode queue: op enum, opcode constants, immediate formats, decoded entry.
// The op enum reserves the RV32M values whether or not YSYX_25060173_RV32M_EN is defined.
package ysyx_25060173_decode_pkg;

    localparam int unsigned OP_ENUM_W = 6;
    localparam int unsigned IMM_W     = 32;
    localparam int unsigned REG_W     = 5;

    typedef enum logic [OP_ENUM_W-1:0] {
        OP_ILLEGAL,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_NOP, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

    localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INST_HALT_JAL = 32'h0000_006f;

    // Decoded instruction minus pc; imm is kept at 32 bits and sign-extended to XLEN at the output.
    typedef struct packed {
        op_e              op;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rd_we;
        logic             illegal;
        logic             ebreak;
    } entry_t;

    function automatic logic [IMM_W-1:0] imm_of(input fmt_e fmt, input logic [31:0] inst);
        logic [IMM_W-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_25060173_decode_comb.sv
// Combinational RV32I decoder: raw instruction word to decoded entry (no pc).
// RV32M encodings are recognised only when YSYX_25060173_RV32M_EN is defined.
module ysyx_25060173_decode_comb
    import ysyx_25060173_decode_pkg::*;
(
    input  logic [31:0] inst,
    output entry_t      entry_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    op_e  op;
    fmt_e fmt;
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic is_shift;

    // Op classification; fmt/use flags are don't-care whenever op stays OP_ILLEGAL.
    always_comb begin
        op       = OP_ILLEGAL;
        fmt      = FMT_R;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        is_shift = 1'b0;
        if (inst == INST_EBREAK || inst == INST_HALT_JAL) begin
            op = OP_EBREAK;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    op = OP_LUI; fmt = FMT_U; use_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    op = OP_AUIPC; fmt = FMT_U; use_rd = 1'b1;
                end
                OPC_JAL: begin
                    op = OP_JAL; fmt = FMT_J; use_rd = 1'b1;
                end
                OPC_JALR: begin
                    fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1;
                    if (funct3 == 3'b000) op = OP_JALR;
                end
                OPC_BRANCH: begin
                    fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case (funct3)
                        3'b000:  op = OP_BEQ;
                        3'b001:  op = OP_BNE;
                        3'b100:  op = OP_BLT;
                        3'b101:  op = OP_BGE;
                        3'b110:  op = OP_BLTU;
                        3'b111:  op = OP_BGEU;
                        default: op = OP_ILLEGAL;
                    endcase
                end
                OPC_LOAD: begin
                    fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1;
                    case (funct3)
                        3'b000:  op = OP_LB;
                        3'b001:  op = OP_LH;
                        3'b010:  op = OP_LW;
                        3'b100:  op = OP_LBU;
                        3'b101:  op = OP_LHU;
                        default: op = OP_ILLEGAL;
                    endcase
                end
                OPC_STORE: begin
                    fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case (funct3)
                        3'b000:  op = OP_SB;
                        3'b001:  op = OP_SH;
                        3'b010:  op = OP_SW;
                        default: op = OP_ILLEGAL;
                    endcase
                end
                OPC_OPIMM: begin
                    fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1;
                    case (funct3)
                        3'b000: op = OP_ADDI;
                        3'b010: op = OP_SLTI;
                        3'b011: op = OP_SLTIU;
                        3'b100: op = OP_XORI;
                        3'b110: op = OP_ORI;
                        3'b111: op = OP_ANDI;
                        3'b001: begin
                            is_shift = 1'b1;
                            if (funct7 == 7'b0000000) op = OP_SLLI;
                        end
                        3'b101: begin
                            is_shift = 1'b1;
                            if (funct7 == 7'b0000000)      op = OP_SRLI;
                            else if (funct7 == 7'b0100000) op = OP_SRAI;
                        end
                    endcase
                end
                OPC_OP: begin
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                    case (funct7)
                        7'b0000000: begin
                            case (funct3)
                                3'b000: op = OP_ADD;
                                3'b001: op = OP_SLL;
                                3'b010: op = OP_SLT;
                                3'b011: op = OP_SLTU;
                                3'b100: op = OP_XOR;
                                3'b101: op = OP_SRL;
                                3'b110: op = OP_OR;
                                3'b111: op = OP_AND;
                            endcase
                        end
                        7'b0100000: begin
                            if (funct3 == 3'b000)      op = OP_SUB;
                            else if (funct3 == 3'b101) op = OP_SRA;
                        end
`ifdef YSYX_25060173_RV32M_EN
                        7'b0000001: begin
                            case (funct3)
                                3'b000: op = OP_MUL;
                                3'b001: op = OP_MULH;
                                3'b010: op = OP_MULHSU;
                                3'b011: op = OP_MULHU;
                                3'b100: op = OP_DIV;
                                3'b101: op = OP_DIVU;
                                3'b110: op = OP_REM;
                                3'b111: op = OP_REMU;
                            endcase
                        end
`endif
                        default: op = OP_ILLEGAL;
                    endcase
                end
                OPC_MISCMEM: begin
                    if (funct3 == 3'b000) op = OP_NOP;
                end
                // ebreak is matched above; ecall and CSR accesses are not supported.
                OPC_SYSTEM: op = OP_ILLEGAL;
                default:    op = OP_ILLEGAL;
            endcase
        end
    end

    // Entry assembly: illegal, nop and ebreak carry no immediate or registers.
    always_comb begin
        entry_c         = '0;
        entry_c.op      = op;
        entry_c.illegal = (op == OP_ILLEGAL);
        entry_c.ebreak  = (op == OP_EBREAK);
        if (op != OP_ILLEGAL) begin
            entry_c.imm   = is_shift ? IMM_W'(inst[24:20]) : imm_of(fmt, inst);
            entry_c.rs1   = use_rs1 ? inst[19:15] : '0;
            entry_c.rs2   = use_rs2 ? inst[24:20] : '0;
            entry_c.rd    = use_rd  ? inst[11:7]  : '0;
            entry_c.rd_we = use_rd && (inst[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/ysyx_25060173_decode_queue.sv
// Buffered RV32I decode stage: decodes at enqueue and holds DEPTH entries in a circular buffer.
// Optional RV32M decode is enabled by defining YSYX_25060173_RV32M_EN.
module ysyx_25060173_decode_queue
    import ysyx_25060173_decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OP_W  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [OP_W-1:0]            out_op,
    output logic [XLEN-1:0]            out_imm,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic                       out_rd_we,
    output logic                       out_illegal,
    output logic                       out_ebreak,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    entry_t          entry_c;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] pc_d  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic full;
    logic empty;
    logic push;
    logic pop;
    entry_t head;

    ysyx_25060173_decode_comb u_decode (
        .inst    (in_inst),
        .entry_c (entry_c)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        pc_d     = pc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_c;
                pc_d[wr_ptr_q]  = in_pc;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: every read is masked by out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        pc_q  <= pc_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign out_pc      = out_valid ? pc_q[rd_ptr_q] : '0;
    assign out_op      = out_valid ? OP_W'(head.op) : '0;
    assign out_imm     = out_valid ? XLEN'($signed(head.imm)) : '0;
    assign out_rs1     = out_valid ? head.rs1 : '0;
    assign out_rs2     = out_valid ? head.rs2 : '0;
    assign out_rd      = out_valid ? head.rd : '0;
    assign out_rd_we   = out_valid && head.rd_we;
    assign out_illegal = out_valid && head.illegal;
    assign out_ebreak  = out_valid && head.ebreak;

endmodule

// File: tb/tb_ysyx_25060173_decode_queue.sv
// Directed bench for the decode queue: single-entry decode vectors plus FIFO/flush/reset sequences.
module tb_ysyx_25060173_decode_queue;
    import ysyx_25060173_decode_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NVEC  = 16;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [OP_W-1:0]  out_op;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_rd_we;
    logic             out_illegal;
    logic             out_ebreak;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    ysyx_25060173_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_ebreak(out_ebreak),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        op_e         op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        ebk;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, OP_ADDI,    32'h00000005, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hfe000ee3, OP_BEQ,     32'hfffffffc, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h00100073, OP_EBREAK,  32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000006f, OP_EBREAK,  32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'hffffffff, OP_ILLEGAL, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
`ifdef YSYX_25060173_RV32M_EN
        vecs[5]  = '{32'h02208033, OP_MUL,     32'h00000000, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0};
`else
        vecs[5]  = '{32'h02208033, OP_ILLEGAL, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
`endif
        vecs[6]  = '{32'h123452b7, OP_LUI,     32'h12345000, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'hfe21ac23, OP_SW,      32'hfffffff8, 5'd3, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h4032d213, OP_SRAI,    32'h00000003, 5'd5, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h02001093, OP_ILLEGAL, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h402081b3, OP_SUB,     32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h008000ef, OP_JAL,     32'h00000008, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{32'hffc3a303, OP_LW,      32'hfffffffc, 5'd7, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'h0ff0000f, OP_NOP,     32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h00000073, OP_ILLEGAL, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{32'h00000013, OP_ADDI,    32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_op", 64'(out_op), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);

        // Decode table: one entry through an empty queue each time
        for (int i = 0; i < int'(NVEC); i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = 32'h80000000 + 32'(i * 4);
            #1 chk($sformatf("v%0d_latency", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_count", i), 64'(count), 64'd1);
            chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h80000000 + 32'(i * 4)));
            chk($sformatf("v%0d_op", i), 64'(out_op), 64'(vecs[i].op));
            chk($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
            chk($sformatf("v%0d_rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
            chk($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_rd_we", i), 64'(out_rd_we), 64'(vecs[i].we));
            chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
            chk($sformatf("v%0d_ebreak", i), 64'(out_ebreak), 64'(vecs[i].ebk));
            pop_one();
            chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
        end

        // Fill, hold, pop with a same-cycle push that must be refused, then wrap
        for (int k = 0; k < int'(DEPTH); k++) begin
            push_one(32'h00500093, 32'h10000000 + 32'(k * 4));
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DEPTH));
        @(negedge clk);
        chk("full_hold_pc", 64'(out_pc), 64'h10000000);
        in_valid  = 1'b1;
        in_inst   = 32'h00700393;
        in_pc     = 32'hdead0000;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("full_pop_count", 64'(count), 64'(DEPTH - 1));
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        push_one(32'h00700393, 32'h20000000);
        chk("wrap_count", 64'(count), 64'(DEPTH));
        for (int k = 1; k < int'(DEPTH); k++) begin
            chk($sformatf("fifo_pc%0d", k), 64'(out_pc), 64'(32'h10000000 + 32'(k * 4)));
            pop_one();
        end
        chk("fifo_wrap_pc", 64'(out_pc), 64'h20000000);
        chk("fifo_wrap_rd", 64'(out_rd), 64'd7);
        pop_one();
        chk("fifo_empty", 64'(out_valid), 64'd0);

        // Flush with push and pop offered in the same cycle
        push_one(32'h00500093, 32'h30000000);
        push_one(32'h00500093, 32'h30000004);
        chk("pre_flush_count", 64'(count), 64'd2);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h3000f000;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("flush_dropped", 64'(out_valid), 64'd0);
        push_one(32'h00300093, 32'h30000100);
        chk("post_flush_pc", 64'(out_pc), 64'h30000100);
        chk("post_flush_imm", 64'(out_imm), 64'd3);
        pop_one();

        // Simultaneous push and pop at count 1
        push_one(32'h00500093, 32'h40000000);
        in_valid  = 1'b1;
        in_inst   = 32'h402081b3;
        in_pc     = 32'h40000004;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pushpop_count", 64'(count), 64'd1);
        chk("pushpop_pc", 64'(out_pc), 64'h40000004);
        chk("pushpop_op", 64'(out_op), 64'(OP_SUB));
        pop_one();

        // Asynchronous reset in the middle of a cycle
        push_one(32'h00500093, 32'h50000000);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25060173_decode_queue.md
Name: ysyx_25060173_decode_queue

Overview:
Buffered RV32I decode stage sitting between instruction fetch and execute in the NPC core.
- Accepts {pc, inst} pairs over a valid/ready handshake and decodes each instruction at enqueue.
- Decode yields a compact op code, immediate, register indices and exception flags.
- Holds up to DEPTH decoded entries in a circular buffer and presents the head to execute over a second valid/ready handshake, with a flush for redirects.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, >= 2.
- XLEN, 32, width of pc and immediate; 32 or 64; immediates are sign-extended to XLEN.
- OP_W, 6, width of the op-code field; must hold every package op enum value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries and any same-cycle input.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  equals !full.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  execute consumes the head.
- out_pc  out  XLEN  head pc.
- out_op  out  OP_W  decoded op enum (OP_ADD, OP_BEQ, OP_LW, ...).
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate; 0 for R-type.
- out_rs1, out_rs2, out_rd  out  5 each  register indices; forced to 0 when unused by the format.
- out_rd_we  out  1  writes rd; forced to 0 when rd==0.
- out_illegal  out  1  unrecognised encoding.
- out_ebreak  out  1  halt request.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset, asynchronous: wr_ptr=0, rd_ptr=0, count=0.
  - This gives out_valid=0 and in_ready=1.
  - All out_* data fields read 0 while empty.
  - Reset asserted mid-operation discards all entries immediately.
- Push when in_valid & in_ready & !flush. The decoded entry is written at wr_ptr, and wr_ptr advances modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop when out_valid & out_ready & !flush. rd_ptr advances modulo DEPTH.
- Latency: an instruction accepted in cycle N appears at the head no earlier than N+1. There is no combinational in->out path.
- Output fields come straight from head storage; they are stable while out_valid & !out_ready.
- Simultaneous push and pop while non-empty and non-full: count unchanged, both pointers advance.
- Full (count==DEPTH): in_ready=0. There is no pass-through, even if a pop occurs the same cycle.
- Empty: out_valid=0. A pop request is ignored.
- Flush has priority over push and pop. The next cycle has count=0, rd_ptr=wr_ptr=0, out_valid=0. in_ready may read 1 during flush, but the transfer is dropped.
- Decode rules:
  - opcode + funct3 + funct7 must match the RV32I encoding exactly. funct7 is checked for R-type and for shift-immediates.
  - ebreak = inst==0x00100073, or inst==0x0000006f (jal x0,0 halt idiom). op=OP_EBREAK, rd_we=0.
  - ecall and fence decode to OP_NOP (fence) or illegal (ecall).
  - Anything unmatched: op=OP_ILLEGAL, illegal=1, rd_we=0, imm=0.
- Immediate formats:
  - I = inst[31:20].
  - S = {inst[31:25],inst[11:7]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U = {inst[31:12],12'b0}.
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All are sign-extended from the top bit to XLEN.
- Shift-immediate shamt = inst[24:20], carried in imm.

Optional Feature:
- Macro: YSYX_25060173_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes to OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU (by funct3), with rd_we per the rd rule.
- Undefined: those encodings are illegal. The op enum values stay reserved in the package.

Decomposition:
- Package ysyx_25060173_decode_pkg holds:
  - the op enum;
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM);
  - the immediate-format enum (FMT_R/I/S/B/U/J);
  - the packed decoded-entry struct.
- One sub-module: ysyx_25060173_decode_comb, purely combinational. It maps inst to the entry minus pc and is instantiated on the push path. The top level holds the storage, pointers and handshakes.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> next cycle out_valid=1, op=OP_ADDI, imm=5, rd=1, rs1=0, rd_we=1.
- Hold out_ready=0 and push DEPTH instructions -> in_ready=0 and count=DEPTH. Then pop with a push offered the same cycle -> push rejected. The next push is accepted and wr_ptr wraps to 0, with entries returned in FIFO order.
- Push 0xfe000ee3 (beq x0,x0,-4) -> op=OP_BEQ, imm=0xfffffffc, rd_we=0, rs1=rs2=0.
- Fill to 2 entries, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the flushed input never appears.
- Push 0x00100073, 0x0000006f, then 0xffffffff -> ebreak=1, ebreak=1, then illegal=1 with op=OP_ILLEGAL and rd_we=0.
- Push 0x02208033 (mul x0,x1,x2) -> with YSYX_25060173_RV32M_EN: op=OP_MUL, rd_we=0 (rd==0). Without it: illegal=1.
